gray_counter_bank: RTL and testbench

Parametrised bank of NUM_CH independent up/down counters. Each counter is readable and writable in Gray or binary code. Commands arrive as packed request-pipe messages and every command returns one packed indication message.
- Sits behind the host request/indication pipes as the successor of the single 4-bit Gray counter.
- Adds channel count, width, saturate mode, status codes and response backpressure.

---
 rtl/gray_counter_bank.sv | 172 +++++++++++++++++
 tb/tb_gray_counter_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_bank.sv
// Bank of NUM_CH up/down counters, stored in binary and readable/writable in
// Gray or binary. One packed response per command through a single-entry buffer.
module gray_counter_bank #(
  parameter int WIDTH    = 4,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0,
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int REQ_W   = 3 + CH_BITS + WIDTH,
  localparam int IND_W   = 2 + REQ_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             request_enq__ENA,
  input  logic [REQ_W-1:0] request_enq_v,
  output logic             request_enq__RDY,
  output logic             indication_enq__ENA,
  output logic [IND_W-1:0] indication_enq_v,
  input  logic             indication_enq__RDY
);

  typedef enum logic [2:0] {
    OP_INCR   = 3'd0,
    OP_DECR   = 3'd1,
    OP_RDGRAY = 3'd2,
    OP_WRGRAY = 3'd3,
    OP_RDBIN  = 3'd4,
    OP_WRBIN  = 3'd5,
    OP_CLRALL = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_WRAPPED   = 2'd1,
    ST_SATURATED = 2'd2,
    ST_ERROR     = 2'd3
  } status_e;

  typedef struct packed {
    status_e              status;
    op_e                  op;
    logic [CH_BITS-1:0]   ch;
    logic [WIDTH-1:0]     data;
  } resp_t;

  localparam logic [CH_BITS:0] NUM_CH_V = (CH_BITS + 1)'(NUM_CH);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0]   cnt_q [NUM_CH];
  logic [WIDTH-1:0]   cnt_d [NUM_CH];
  logic               resp_valid_q, resp_valid_d;
  resp_t              resp_q, resp_d;

  op_e                req_op;
  logic [CH_BITS-1:0] req_ch;
  logic [WIDTH-1:0]   req_data;
  logic               ch_ok;
  logic [CH_BITS-1:0] ch_idx;
  logic [WIDTH-1:0]   cur, cur_inc, cur_dec;
  logic               accept, drain;

  assign req_op   = op_e'(request_enq_v[REQ_W-1 -: 3]);
  assign req_ch   = request_enq_v[WIDTH +: CH_BITS];
  assign req_data = request_enq_v[WIDTH-1:0];

  // Out-of-range channels are steered to index 0 so the read mux never
  // leaves the array; such commands are turned into ERROR below anyway.
  assign ch_ok   = {1'b0, req_ch} < NUM_CH_V;
  assign ch_idx  = ch_ok ? req_ch : '0;
  assign cur     = cnt_q[ch_idx];
  assign cur_inc = cur + WIDTH'(1);
  assign cur_dec = cur - WIDTH'(1);

  assign request_enq__RDY    = !resp_valid_q || indication_enq__RDY;
  assign indication_enq__ENA = resp_valid_q && indication_enq__RDY;
  assign indication_enq_v    = resp_q;
  assign accept              = request_enq__ENA && request_enq__RDY;
  assign drain               = resp_valid_q && indication_enq__RDY;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q && !drain;

    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_d.status = ST_OK;
      resp_d.op     = req_op;
      resp_d.ch     = req_ch;
      resp_d.data   = '0;

      if (!ch_ok && req_op != OP_CLRALL) begin
        resp_d.status = ST_ERROR;
      end else begin
        case (req_op)
          OP_INCR: begin
            if (cur == '1) begin
              if (SATURATE != 0) begin
                resp_d.status = ST_SATURATED;
                resp_d.data   = bin2gray(cur);
              end else begin
                resp_d.status = ST_WRAPPED;
                cnt_d[ch_idx] = '0;
              end
            end else begin
              cnt_d[ch_idx] = cur_inc;
              resp_d.data   = bin2gray(cur_inc);
            end
          end
          OP_DECR: begin
            if (cur == '0) begin
              if (SATURATE != 0) begin
                resp_d.status = ST_SATURATED;
              end else begin
                resp_d.status = ST_WRAPPED;
                cnt_d[ch_idx] = '1;
                resp_d.data   = bin2gray('1);
              end
            end else begin
              cnt_d[ch_idx] = cur_dec;
              resp_d.data   = bin2gray(cur_dec);
            end
          end
          OP_RDGRAY: resp_d.data = bin2gray(cur);
          OP_WRGRAY: begin
            cnt_d[ch_idx] = gray2bin(req_data);
            resp_d.data   = req_data;
          end
          OP_RDBIN:  resp_d.data = cur;
          OP_WRBIN: begin
            cnt_d[ch_idx] = req_data;
            resp_d.data   = req_data;
          end
          OP_CLRALL: begin
            for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
          end
          default:   resp_d.status = ST_ERROR;
        endcase
      end
    end
  end

  // NOTE: the counter array is a handful of flops rather than a RAM, so it
  // is reset like any other register; non-blocking updates keep every
  // register sampling the same pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

endmodule

// File: tb/tb_gray_counter_bank.sv
// Self-checking bench: a wrapping bank (4 ch) and a saturating bank (5 ch),
// directed tables, handshake/reset sequences and a randomized model check.
module tb_gray_counter_bank;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_req_ena, a_req_rdy, a_ind_ena, a_ind_rdy;
  logic [8:0]  a_req_v;
  logic [10:0] a_ind_v;
  logic        b_req_ena, b_req_rdy, b_ind_ena, b_ind_rdy;
  logic [9:0]  b_req_v;
  logic [11:0] b_ind_v;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl [2][8];

  always #5 clk = ~clk;

  gray_counter_bank #(.WIDTH(4), .NUM_CH(4), .SATURATE(0)) dut_a (
    .CLK(clk), .RST(rst),
    .request_enq__ENA(a_req_ena), .request_enq_v(a_req_v), .request_enq__RDY(a_req_rdy),
    .indication_enq__ENA(a_ind_ena), .indication_enq_v(a_ind_v), .indication_enq__RDY(a_ind_rdy)
  );

  gray_counter_bank #(.WIDTH(4), .NUM_CH(5), .SATURATE(1)) dut_b (
    .CLK(clk), .RST(rst),
    .request_enq__ENA(b_req_ena), .request_enq_v(b_req_v), .request_enq__RDY(b_req_rdy),
    .indication_enq__ENA(b_ind_ena), .indication_enq_v(b_ind_v), .indication_enq__RDY(b_ind_rdy)
  );

  typedef struct {
    int sel; int op; int ch; int data; int st; int d;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int st, input int op, input int ch, input int d);
    return 32'((st << 20) | (op << 16) | (ch << 8) | d);
  endfunction

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  // Inverse Gray by exhaustive search over the 4-bit code space.
  function automatic int ungray(input int g);
    for (int b = 0; b < 16; b++) if (gray(b) == g) return b;
    return 0;
  endfunction

  task automatic model_step(input int sel, input int op, input int ch, input int data,
                            output logic [31:0] key);
    int nch, v, st, d;
    nch = (sel == 0) ? 4 : 5;
    st  = 0;
    d   = 0;
    if (op == 7 || (op != 6 && ch >= nch)) begin
      st = 3;
    end else begin
      case (op)
        0: begin
          v = mdl[sel][ch] + 1;
          if (v > 15) begin
            if (sel == 1) begin st = 2; v = 15; end
            else          begin st = 1; v = 0;  end
          end
          mdl[sel][ch] = v;
          d = gray(v);
        end
        1: begin
          v = mdl[sel][ch] - 1;
          if (v < 0) begin
            if (sel == 1) begin st = 2; v = 0;  end
            else          begin st = 1; v = 15; end
          end
          mdl[sel][ch] = v;
          d = gray(v);
        end
        2: d = gray(mdl[sel][ch]);
        3: begin mdl[sel][ch] = ungray(data); d = data; end
        4: d = mdl[sel][ch];
        5: begin mdl[sel][ch] = data; d = data; end
        default: for (int i = 0; i < 8; i++) mdl[sel][i] = 0;
      endcase
    end
    key = mk(st, op, ch, d);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) for (int i = 0; i < 8; i++) mdl[s][i] = 0;
  endtask

  task automatic drive(input int sel, input logic ena, input int op, input int ch, input int data);
    logic [2:0] o, c;
    logic [3:0] dd;
    o  = op[2:0];
    c  = ch[2:0];
    dd = data[3:0];
    if (sel == 0) begin a_req_ena = ena; a_req_v = {o, c[1:0], dd}; end
    else          begin b_req_ena = ena; b_req_v = {o, c, dd}; end
  endtask

  function automatic logic [31:0] resp_key(input int sel);
    if (sel == 0) return mk(int'(a_ind_v[10:9]), int'(a_ind_v[8:6]), int'(a_ind_v[5:4]), int'(a_ind_v[3:0]));
    return mk(int'(b_ind_v[11:10]), int'(b_ind_v[9:7]), int'(b_ind_v[6:4]), int'(b_ind_v[3:0]));
  endfunction

  // One command: drive at a falling edge, accepted at the next rising edge,
  // response sampled at the following falling edge.
  task automatic issue(input int sel, input int op, input int ch, input int data,
                       output logic [31:0] key, output logic ena_seen, output logic rdy_seen);
    @(negedge clk);
    drive(sel, 1'b1, op, ch, data);
    rdy_seen = (sel == 0) ? a_req_rdy : b_req_rdy;
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 0, 0, 0);
    ena_seen = (sel == 0) ? a_ind_ena : b_ind_ena;
    key      = resp_key(sel);
  endtask

  task automatic run_cmd(input string name, input int sel, input int op, input int ch,
                         input int data, input logic [31:0] exp);
    logic [31:0] act, mexp;
    logic ena, rdy;
    model_step(sel, op, ch, data, mexp);
    issue(sel, op, ch, data, act, ena, rdy);
    check({name, " req_rdy"}, 32'(rdy), 32'd1);
    check({name, " ind_ena"}, 32'(ena), 32'd1);
    check(name, act, exp);
  endtask

  logic [31:0] gseq [16] = '{32'h1, 32'h3, 32'h2, 32'h6, 32'h7, 32'h5, 32'h4, 32'hC,
                             32'hD, 32'hF, 32'hE, 32'hA, 32'hB, 32'h9, 32'h8, 32'h0};

  initial begin
    vec_t tbl[$];
    logic [31:0] act, exp;
    logic ena, rdy;
    int op, ch, data;

    tbl.push_back('{0, 3, 2, 'hD, 0, 'hD});
    tbl.push_back('{0, 4, 2, 0,   0, 'h9});
    tbl.push_back('{0, 5, 3, 'hA, 0, 'hA});
    tbl.push_back('{0, 2, 3, 0,   0, 'hF});
    tbl.push_back('{0, 7, 1, 5,   3, 0});
    tbl.push_back('{0, 2, 1, 0,   0, 0});
    tbl.push_back('{1, 5, 0, 'hF, 0, 'hF});
    tbl.push_back('{1, 0, 0, 0,   2, 'h8});
    tbl.push_back('{1, 4, 0, 0,   0, 'hF});
    tbl.push_back('{1, 1, 1, 0,   2, 0});
    tbl.push_back('{1, 4, 1, 0,   0, 0});
    tbl.push_back('{1, 0, 5, 3,   3, 0});
    tbl.push_back('{1, 4, 7, 0,   3, 0});
    tbl.push_back('{1, 7, 0, 0,   3, 0});
    tbl.push_back('{1, 5, 4, 3,   0, 3});
    tbl.push_back('{1, 1, 4, 0,   0, 3});
    tbl.push_back('{1, 3, 4, 'hF, 0, 'hF});
    tbl.push_back('{1, 4, 4, 0,   0, 'hA});
    tbl.push_back('{1, 6, 6, 0,   0, 0});
    tbl.push_back('{1, 4, 0, 0,   0, 0});
    tbl.push_back('{1, 4, 4, 0,   0, 0});

    rst = 1'b1;
    a_ind_rdy = 1'b1;
    b_ind_rdy = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset ind_ena a", 32'(a_ind_ena), 32'd0);
    check("reset ind_ena b", 32'(b_ind_ena), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset req_rdy a", 32'(a_req_rdy), 32'd1);
    check("post-reset req_rdy b", 32'(b_req_rdy), 32'd1);

    run_cmd("rdgray ch0", 0, 2, 0, 0, mk(0, 2, 0, 0));
    for (int i = 0; i < 16; i++)
      run_cmd($sformatf("incr ch1 #%0d", i), 0, 0, 1, 0, mk((i == 15) ? 1 : 0, 0, 1, int'(gseq[i])));
    run_cmd("rdbin ch0 untouched", 0, 4, 0, 0, mk(0, 4, 0, 0));
    run_cmd("rdbin ch2 untouched", 0, 4, 2, 0, mk(0, 4, 2, 0));

    foreach (tbl[i])
      run_cmd($sformatf("table %0d sel%0d op%0d ch%0d", i, tbl[i].sel, tbl[i].op, tbl[i].ch),
              tbl[i].sel, tbl[i].op, tbl[i].ch, tbl[i].data,
              mk(tbl[i].st, tbl[i].op, tbl[i].ch, tbl[i].d));

    // Backpressure: two commands offered while the consumer stalls.
    @(negedge clk);
    a_ind_rdy = 1'b0;
    drive(0, 1'b1, 4, 3, 0);
    model_step(0, 4, 3, 0, exp);
    check("bp first req_rdy", 32'(a_req_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 0, 3, 0);
    check("bp stalled req_rdy", 32'(a_req_rdy), 32'd0);
    check("bp stalled ind_ena", 32'(a_ind_ena), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp still stalled req_rdy", 32'(a_req_rdy), 32'd0);
    check("bp held resp", resp_key(0), mk(0, 4, 3, 'hA));
    a_ind_rdy = 1'b1;
    #1;
    check("bp drain ind_ena 1", 32'(a_ind_ena), 32'd1);
    check("bp drain resp 1", resp_key(0), exp);
    check("bp pass-through req_rdy", 32'(a_req_rdy), 32'd1);
    model_step(0, 0, 3, 0, exp);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 0);
    check("bp drain ind_ena 2", 32'(a_ind_ena), 32'd1);
    check("bp drain resp 2", resp_key(0), mk(0, 0, 3, 'hE));
    check("bp drain resp 2 model", resp_key(0), exp);
    @(posedge clk);
    @(negedge clk);
    check("bp idle ind_ena", 32'(a_ind_ena), 32'd0);

    // Reset while a response is still pending.
    a_ind_rdy = 1'b0;
    drive(0, 1'b1, 5, 0, 5);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    a_ind_rdy = 1'b1;
    #1;
    check("rst pending ind_ena", 32'(a_ind_ena), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst release ind_ena", 32'(a_ind_ena), 32'd0);
    check("rst release req_rdy", 32'(a_req_rdy), 32'd1);
    for (int c = 0; c < 4; c++)
      run_cmd($sformatf("post-rst rdbin ch%0d", c), 0, 4, c, 0, mk(0, 4, c, 0));

    // Randomized traffic against the reference model on both banks.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel  = (i % 2);
      op   = $urandom_range(0, 7);
      ch   = (sel == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7);
      data = $urandom_range(0, 15);
      model_step(sel, op, ch, data, exp);
      issue(sel, op, ch, data, act, ena, rdy);
      check($sformatf("rand %0d sel%0d op%0d ch%0d d%0h ena", i, sel, op, ch, data), 32'(ena), 32'd1);
      check($sformatf("rand %0d sel%0d op%0d ch%0d d%0h", i, sel, op, ch, data), act, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
